// File: rtl/instruction_fetch.sv
// Fetch stage: PC, one-cycle memory latency, 2-entry {pc, inst} buffer to decode.
// Optional fetch bounds checking is enabled by defining IFETCH_BOUNDS_CHECK_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC       = 32'd0,
    parameter int unsigned INST_MEM_DEPTH = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] addr,
    input  logic [31:0] instruction,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);

`ifdef IFETCH_BOUNDS_CHECK_EN
    localparam bit BoundsCheck = 1'b1;
`else
    localparam bit BoundsCheck = 1'b0;
`endif

    typedef enum logic {StRun, StFault} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        req_valid_q, req_valid_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] head_pc_q, head_pc_d;
    logic [31:0] head_inst_q, head_inst_d;
    logic [31:0] tail_pc_q, tail_pc_d;
    logic [31:0] tail_inst_q, tail_inst_d;
    logic [1:0]  count_q, count_d;
    logic [31:0] fault_pc_q, fault_pc_d;

    logic        pop;
    logic [2:0]  occupancy;
    logic        room;
    logic        bad_pc;
    logic        fault_hit;
    logic        issue;
    logic [1:0]  count_tmp;
    logic [31:0] target;

    assign pop        = inst_valid & inst_ready;
    // Words still owed to decode after this cycle: buffered minus popped plus in flight.
    assign occupancy  = {1'b0, count_q} - {2'b00, pop} + {2'b00, req_valid_q};
    assign room       = occupancy < 3'd2;
    assign bad_pc     = (fetch_pc_q >= 32'(INST_MEM_DEPTH)) || (fetch_pc_q[1:0] != 2'b00);
    assign fault_hit  = BoundsCheck && bad_pc;
    assign target     = BoundsCheck ? redirect_target : {redirect_target[31:2], 2'b00};

    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        req_valid_d = 1'b0;
        req_pc_d    = req_pc_q;
        head_pc_d   = head_pc_q;
        head_inst_d = head_inst_q;
        tail_pc_d   = tail_pc_q;
        tail_inst_d = tail_inst_q;
        fault_pc_d  = fault_pc_q;
        issue       = 1'b0;
        count_tmp   = count_q;

        if (state_q == StRun) begin
            if (fault_hit) begin
                state_d    = StFault;
                fault_pc_d = fetch_pc_q;
            end else if (room) begin
                issue = 1'b1;
            end
        end

        if (issue) begin
            req_valid_d = 1'b1;
            req_pc_d    = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + 32'd4;
        end

        if (pop) begin
            head_pc_d   = tail_pc_q;
            head_inst_d = tail_inst_q;
            count_tmp   = count_tmp - 2'd1;
        end

        // The issue rule keeps at least one slot free whenever a word returns.
        if (req_valid_q) begin
            if (count_tmp == 2'd0) begin
                head_pc_d   = req_pc_q;
                head_inst_d = instruction;
            end else begin
                tail_pc_d   = req_pc_q;
                tail_inst_d = instruction;
            end
            count_tmp = count_tmp + 2'd1;
        end

        count_d = count_tmp;

        if (redirect_valid) begin
            count_d     = 2'd0;
            req_valid_d = 1'b0;
            fetch_pc_d  = target;
            state_d     = StRun;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StRun;
            fetch_pc_q  <= RESET_PC;
            req_valid_q <= 1'b0;
            req_pc_q    <= 32'd0;
            head_pc_q   <= 32'd0;
            head_inst_q <= 32'd0;
            tail_pc_q   <= 32'd0;
            tail_inst_q <= 32'd0;
            count_q     <= 2'd0;
            fault_pc_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_valid_q <= req_valid_d;
            req_pc_q    <= req_pc_d;
            head_pc_q   <= head_pc_d;
            head_inst_q <= head_inst_d;
            tail_pc_q   <= tail_pc_d;
            tail_inst_q <= tail_inst_d;
            count_q     <= count_d;
            fault_pc_q  <= fault_pc_d;
        end
    end

    assign addr        = fetch_pc_q;
    assign inst_valid  = (count_q != 2'd0);
    assign inst_out    = head_inst_q;
    assign inst_pc     = head_pc_q;
    assign fetch_fault = BoundsCheck && (state_q == StFault);
    assign fault_pc    = BoundsCheck ? fault_pc_q : 32'd0;

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomized scoreboard bench for instruction_fetch against a sequential-stream model.
module tb_instruction_fetch;

    localparam logic [31:0] ResetPc = 32'd0;
    localparam int unsigned Depth   = 2048;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic [31:0] fault_pc;

    int n_cmp = 0;
    int n_fail = 0;
    int n_hs = 0;

    logic [31:0] exp_q[$];
    logic [31:0] flush_q[$];

    instruction_fetch #(
        .RESET_PC      (ResetPc),
        .INST_MEM_DEPTH(Depth)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr           (addr),
        .instruction    (instruction),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault),
        .fault_pc       (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word i holds i; addresses wrap through the memory size.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a % 32'(Depth)) >> 2;
    endfunction

    function automatic bit in_range(input logic [31:0] pc);
`ifdef IFETCH_BOUNDS_CHECK_EN
        return (pc < 32'(Depth)) && (pc[1:0] == 2'b00);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] eff_target(input logic [31:0] t);
`ifdef IFETCH_BOUNDS_CHECK_EN
        return t;
`else
        return {t[31:2], 2'b00};
`endif
    endfunction

    always @(posedge clk) instruction <= word_of(addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic step(input logic r, input logic rd, input logic [31:0] tg, input logic rn);
        @(posedge clk);
        #1;
        inst_ready      = r;
        redirect_valid  = rd;
        redirect_target = tg;
        rst_n           = rn;
        if (rd && rn) flush_q.push_back(eff_target(tg));
    endtask

    // Monitor: the expected stream is pc, pc+4, ... from the last redirect/reset target.
    int          mc = 0;
    int          flush_mc = 0;
    int          age;
    logic [31:0] flush_pc = 32'd0;
    logic [31:0] next_pc = 32'd0;
    logic [31:0] model_fault_pc = 32'd0;
    logic [31:0] prev_pc = 32'd0;
    logic [31:0] prev_out = 32'd0;
    logic [31:0] want_pc;
    bit          fault_known = 1'b0;
    bit          prev_rst_low = 1'b0;
    bit          prev_stall = 1'b0;

    task automatic do_flush(input logic [31:0] t);
        exp_q.delete();
        next_pc     = t;
        fault_known = 1'b0;
        flush_mc    = mc;
        flush_pc    = t;
    endtask

    task automatic refill();
        while (exp_q.size() < 4 && !fault_known) begin
            if (in_range(next_pc)) begin
                exp_q.push_back(next_pc);
                next_pc = next_pc + 32'd4;
            end else begin
                fault_known    = 1'b1;
                model_fault_pc = next_pc;
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mc++;
            if (prev_rst_low) begin
                chk("rst_valid", 32'(inst_valid), 32'd0);
                chk("rst_inst_out", inst_out, 32'd0);
                chk("rst_inst_pc", inst_pc, 32'd0);
                chk("rst_addr", addr, ResetPc);
                chk("rst_fault", 32'(fetch_fault), 32'd0);
                chk("rst_fault_pc", fault_pc, 32'd0);
            end
            if (!rst_n) begin
                do_flush(ResetPc);
                prev_rst_low = 1'b1;
                prev_stall   = 1'b0;
            end else begin
                prev_rst_low = 1'b0;
                age = mc - flush_mc;
                if (age == 1) begin
                    chk("flush_valid_low", 32'(inst_valid), 32'd0);
                    chk("flush_addr", addr, flush_pc);
                    chk("flush_fault_clear", 32'(fetch_fault), 32'd0);
                end
`ifndef IFETCH_BOUNDS_CHECK_EN
                chk("fault_tied", 32'(fetch_fault), 32'd0);
                chk("fault_pc_tied", fault_pc, 32'd0);
`endif
                if (prev_stall) begin
                    chk("stall_valid", 32'(inst_valid), 32'd1);
                    chk("stall_pc", inst_pc, prev_pc);
                    chk("stall_out", inst_out, prev_out);
                end
                if (age >= 3 && exp_q.size() > 0) chk("stream_valid", 32'(inst_valid), 32'd1);
                if (age >= 3 && inst_valid && in_range(inst_pc + 32'd8))
                    chk("fetch_ahead", addr, inst_pc + 32'd8);
`ifdef IFETCH_BOUNDS_CHECK_EN
                if (fault_known && !inst_valid && age >= 3) begin
                    chk("fault_set", 32'(fetch_fault), 32'd1);
                    chk("fault_pc", fault_pc, model_fault_pc);
                end
                if (!fault_known) chk("no_fault", 32'(fetch_fault), 32'd0);
`endif
                if (inst_valid && inst_ready) begin
                    n_hs++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_word", inst_pc, next_pc);
                    end else begin
                        want_pc = exp_q.pop_front();
                        chk("inst_pc", inst_pc, want_pc);
                        chk("inst_out", inst_out, word_of(want_pc));
                    end
                end
                prev_stall = inst_valid && !inst_ready && !redirect_valid;
                prev_pc    = inst_pc;
                prev_out   = inst_out;
                if (redirect_valid) begin
                    if (flush_q.size() == 0) chk("flush_q_empty", 32'd0, 32'd1);
                    else do_flush(flush_q.pop_front());
                end
            end
            refill();
        end
    end

    initial begin
        int          stall_left;
        logic        r;
        logic        rd;
        logic [31:0] tg;
        stall_left      = 0;
        rst_n           = 1'b0;
        inst_ready      = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        repeat (20) step(1'b1, 1'b0, 32'd0, 1'b1);
        repeat (6) step(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        // Redirect while two words are buffered and decode is stalled.
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'h40, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'd5, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'd2040, 1'b1);
        repeat (12) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'd0, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1);
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                step(1'b1, 1'b0, 32'd0, 1'b0);
                step(1'b0, 1'b0, 32'd0, 1'b0);
            end else begin
                if ($urandom_range(0, 63) == 0) stall_left = $urandom_range(3, 8);
                if (stall_left > 0) begin
                    r = 1'b0;
                    stall_left--;
                end else begin
                    r = ($urandom_range(0, 3) != 0);
                end
                rd = ($urandom_range(0, 23) == 0);
                if ($urandom_range(0, 3) == 0) tg = $urandom();
                else tg = $urandom_range(0, Depth + 16);
                step(r, rd, tg, 1'b1);
            end
        end
        repeat (10) step(1'b1, 1'b0, 32'd0, 1'b1);
        @(posedge clk);
        #1;
        chk("deliveries", 32'(n_hs >= 50), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
